// File: rtl/fifo_word_reader.sv
// Read-side consumer for the 8-bit async FIFO: drains bytes with one-cycle read latency
// and packs them little-endian into words on a valid/ready stream, with flush support.
module fifo_word_reader #(
    parameter int BYTES_PER_WORD = 4,
    parameter int CNT_W          = 16
) (
    input  logic                        rd_clk,
    input  logic                        rd_rst,
    input  logic                        fifo_empty,
    input  logic [7:0]                  fifo_out,
    output logic                        rd_en,
    input  logic                        flush,
    output logic [8*BYTES_PER_WORD-1:0] m_data,
    output logic [BYTES_PER_WORD-1:0]   m_keep,
    output logic                        m_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [CNT_W-1:0]            words_out
);

    localparam int DW = 8 * BYTES_PER_WORD;
    localparam int CW = $clog2(BYTES_PER_WORD + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(BYTES_PER_WORD);

    logic [DW-1:0]             asm_q, asm_d;
    logic [CW-1:0]             asm_cnt_q, asm_cnt_d;
    logic                      rd_pending_q, rd_pending_d;
    logic [DW-1:0]             m_data_q, m_data_d;
    logic [BYTES_PER_WORD-1:0] m_keep_q, m_keep_d;
    logic                      m_last_q, m_last_d;
    logic                      m_valid_q, m_valid_d;
    logic                      flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]          words_out_q, words_out_d;

    logic                      xfer;
    logic                      accept;
    logic [CW:0]               slots_used;
    logic [BYTES_PER_WORD-1:0] keep_mask;
    logic [DW-1:0]             masked_word;

    // A lane is committed as soon as its read is strobed, so slots count the byte in flight.
    always_comb begin
        slots_used = {1'b0, asm_cnt_q} + {{CW{1'b0}}, rd_pending_q};
        accept     = m_valid_q && m_ready;
        xfer       = ((asm_cnt_q == FULL_CNT) ||
                      (flush_pend_q && !rd_pending_q && (asm_cnt_q != '0))) &&
                     (!m_valid_q || m_ready);
        rd_en      = !rd_rst && !fifo_empty && !flush_pend_q &&
                     ((slots_used < (CW+1)'(BYTES_PER_WORD)) || xfer);
    end

    always_comb begin
        keep_mask   = BYTES_PER_WORD'((1 << asm_cnt_q) - 1);
        masked_word = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            masked_word[i*8 +: 8] = keep_mask[i] ? asm_q[i*8 +: 8] : 8'h00;
        end

        asm_d        = asm_q;
        asm_cnt_d    = asm_cnt_q;
        rd_pending_d = rd_en;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;
        m_valid_d    = m_valid_q;
        flush_pend_d = flush_pend_q;
        words_out_d  = words_out_q + CNT_W'(accept);

        // Emptying the assembly first lets a byte landing on the same edge fall into lane 0.
        if (xfer) begin
            asm_d     = '0;
            asm_cnt_d = '0;
        end
        if (rd_pending_q) begin
            asm_d[asm_cnt_d*8 +: 8] = fifo_out;
            asm_cnt_d               = asm_cnt_d + CW'(1);
        end

        if (xfer) begin
            m_data_d  = masked_word;
            m_keep_d  = keep_mask;
            m_last_d  = flush_pend_q;
            m_valid_d = 1'b1;
        end else if (accept) begin
            m_valid_d = 1'b0;
        end

        if (!flush_pend_q) begin
            flush_pend_d = flush;
        end else if (!rd_pending_q && ((asm_cnt_q == '0) || xfer)) begin
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            asm_q        <= '0;
            asm_cnt_q    <= '0;
            rd_pending_q <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
            m_valid_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            words_out_q  <= '0;
        end else begin
            asm_q        <= asm_d;
            asm_cnt_q    <= asm_cnt_d;
            rd_pending_q <= rd_pending_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
            m_valid_q    <= m_valid_d;
            flush_pend_q <= flush_pend_d;
            words_out_q  <= words_out_d;
        end
    end

    assign m_data    = m_data_q;
    assign m_keep    = m_keep_q;
    assign m_last    = m_last_q;
    assign m_valid   = m_valid_q;
    assign words_out = words_out_q;

endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed bench for fifo_word_reader: behavioural FIFO read port with one-cycle latency
// feeding the DUT, and a log of every word accepted on the output stream.
module tb_fifo_word_reader;

    logic        rd_clk;
    logic        rd_rst;
    logic        fifo_empty;
    logic [7:0]  fifo_out = 8'h00;
    logic        rd_en;
    logic        flush;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] words_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]  fifo_mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [36:0] acc_log [0:63];
    int          acc_cnt = 0;
    int          empty_reads = 0;

    fifo_word_reader #(.BYTES_PER_WORD(4), .CNT_W(16)) dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .fifo_empty (fifo_empty),
        .fifo_out   (fifo_out),
        .rd_en      (rd_en),
        .flush      (flush),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .words_out  (words_out)
    );

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO read port: data appears on fifo_out the edge after rd_en.
    always @(posedge rd_clk) begin
        if (rd_en) begin
            fifo_out <= fifo_mem[rd_ptr[7:0]];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    // Sampled mid-cycle: m_valid && m_ready here means the word is accepted on the next edge.
    always @(negedge rd_clk) begin
        if (rd_en && fifo_empty) empty_reads <= empty_reads + 1;
        if (!rd_rst && m_valid && m_ready && acc_cnt < 64) begin
            acc_log[acc_cnt[5:0]] <= {m_last, m_keep, m_data};
            acc_cnt               <= acc_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        fifo_mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic waitWords(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (acc_cnt < target && n < budget) begin
            waitCycles(1);
            n++;
        end
        checkOutput(tag, 64'(acc_cnt), 64'(target));
    endtask

    initial begin
        rd_rst  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;

        // Reset asserted between edges must clear outputs without a clock.
        #2 rd_rst = 1'b1;
        #1;
        checkOutput("reset_m_data",    64'(m_data),    64'h0);
        checkOutput("reset_m_keep",    64'(m_keep),    64'h0);
        checkOutput("reset_m_last",    64'(m_last),    64'h0);
        checkOutput("reset_m_valid",   64'(m_valid),   64'h0);
        checkOutput("reset_words_out", 64'(words_out), 64'h0);
        checkOutput("reset_rd_en",     64'(rd_en),     64'h0);

        for (int i = 0; i < 64; i++) applyStimulus(8'(i));
        for (int i = 0; i < 3; i++) begin
            waitCycles(1);
            checkOutput("reset_rd_en_hold", 64'(rd_en), 64'h0);
        end

        // Full stream of 64 bytes.
        m_ready = 1'b1;
        rd_rst  = 1'b0;
        waitWords(16, 200, "stream_word_count");
        waitCycles(2);
        for (int i = 0; i < 16; i++) begin
            checkOutput("stream_word", 64'(acc_log[i]),
                        64'({1'b0, 4'hF, 8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}));
        end
        checkOutput("stream_words_out", 64'(words_out), 64'd16);
        checkOutput("stream_fifo_empty", 64'(fifo_empty), 64'h1);

        // Backpressure: first word stalls, assembly fills to four lanes.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(8'(i));
        waitCycles(15);
        checkOutput("bp_word", 64'({m_valid, m_last, m_keep, m_data}), 64'({1'b1, 1'b0, 4'hF, 32'h03020100}));
        checkOutput("bp_asm_cnt", 64'(dut.asm_cnt_q), 64'd4);
        checkOutput("bp_rd_pending", 64'(dut.rd_pending_q), 64'h0);
        checkOutput("bp_rd_en", 64'(rd_en), 64'h0);
        checkOutput("bp_fifo_drained", 64'(fifo_empty), 64'h1);
        waitCycles(4);
        checkOutput("bp_hold", 64'({m_valid, m_last, m_keep, m_data}), 64'({1'b1, 1'b0, 4'hF, 32'h03020100}));
        checkOutput("bp_words_out_hold", 64'(words_out), 64'd16);
        m_ready = 1'b1;
        waitWords(18, 20, "bp_word_count");
        waitCycles(2);
        checkOutput("bp_word0", 64'(acc_log[16]), 64'({1'b0, 4'hF, 32'h03020100}));
        checkOutput("bp_word1", 64'(acc_log[17]), 64'({1'b0, 4'hF, 32'h07060504}));
        checkOutput("bp_words_out", 64'(words_out), 64'd18);
        checkOutput("bp_fifo_end_empty", 64'(fifo_empty), 64'h1);

        // Flush of a three-byte partial word.
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        applyStimulus(8'hCC);
        waitCycles(8);
        checkOutput("fl_pre_cnt", 64'(dut.asm_cnt_q), 64'd3);
        flush = 1'b1;
        waitCycles(1);
        flush = 1'b0;
        checkOutput("fl_pend_set", 64'(dut.flush_pend_q), 64'h1);
        checkOutput("fl_not_yet_valid", 64'(m_valid), 64'h0);
        waitCycles(1);
        checkOutput("fl_word", 64'({m_valid, m_last, m_keep, m_data}), 64'({1'b1, 1'b1, 4'b0111, 32'h00CCBBAA}));
        checkOutput("fl_pend_clear", 64'(dut.flush_pend_q), 64'h0);
        waitCycles(2);
        checkOutput("fl_words_out", 64'(words_out), 64'd19);

        // Flush with nothing assembled and no read in flight.
        flush = 1'b1;
        waitCycles(1);
        flush = 1'b0;
        checkOutput("fe_pend_set", 64'(dut.flush_pend_q), 64'h1);
        waitCycles(1);
        checkOutput("fe_pend_clear", 64'(dut.flush_pend_q), 64'h0);
        checkOutput("fe_no_valid", 64'(m_valid), 64'h0);
        waitCycles(3);
        checkOutput("fe_no_word", 64'(acc_cnt), 64'd19);
        checkOutput("fe_words_out", 64'(words_out), 64'd19);

        // Reads resume after a flush completes.
        applyStimulus(8'hDD);
        applyStimulus(8'hEE);
        waitCycles(6);
        checkOutput("resume_cnt", 64'(dut.asm_cnt_q), 64'd2);
        flush = 1'b1;
        waitCycles(1);
        flush = 1'b0;
        waitCycles(1);
        checkOutput("resume_word", 64'({m_valid, m_last, m_keep, m_data}), 64'({1'b1, 1'b1, 4'b0011, 32'h0000EEDD}));
        waitCycles(2);

        // Reset in the middle of assembling a word.
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        waitCycles(6);
        checkOutput("rst_pre_cnt", 64'(dut.asm_cnt_q), 64'd2);
        checkOutput("rst_pre_asm", 64'(dut.asm_q), 64'h00002211);
        rd_rst = 1'b1;
        #1;
        checkOutput("rst_asm", 64'(dut.asm_q), 64'h0);
        checkOutput("rst_asm_cnt", 64'(dut.asm_cnt_q), 64'h0);
        checkOutput("rst_m_valid", 64'(m_valid), 64'h0);
        checkOutput("rst_words_out", 64'(words_out), 64'h0);
        checkOutput("rst_rd_en", 64'(rd_en), 64'h0);
        waitCycles(1);
        rd_rst = 1'b0;
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        applyStimulus(8'h55);
        applyStimulus(8'h66);
        waitWords(21, 30, "rst_word_count");
        waitCycles(2);
        checkOutput("rst_word", 64'(acc_log[20]), 64'({1'b0, 4'hF, 32'h66554433}));
        checkOutput("rst_words_out_after", 64'(words_out), 64'd1);

        checkOutput("no_read_when_empty", 64'(empty_reads), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_word_reader.md
# fifo_word_reader

Read-side consumer for the 8-bit async FIFO, running entirely in the read clock domain. It drains bytes from the FIFO read port (`rd_en`/`fifo_out`/`fifo_empty`) and accounts for the FIFO's one-cycle read latency. It packs the bytes little-endian into 32-bit words on a valid/ready stream toward downstream logic. A flush request emits any partial word with byte-enable and end marker.

## Interface
- `BYTES_PER_WORD`, default 4: lanes per output word; this block is specified and verified at 4 only.
- `CNT_W`, default 16: width of the `words_out` statistics counter.

Ports:
- `rd_clk`  in  1  — single clock, shared with the FIFO read side.
- `rd_rst`  in  1  — asynchronous, active-high reset.
- `fifo_empty`  in  1  — FIFO empty flag.
- `fifo_out`  in  8  — FIFO read data, valid one cycle after `rd_en`.
- `rd_en`  out  1  — FIFO read strobe.
- `flush`  in  1  — single-cycle pulse requesting emission of the partial word.
- `m_data`  out  32  — output word; first byte read sits in lane 0, bits [7:0].
- `m_keep`  out  4  — per-lane byte valid.
- `m_last`  out  1  — marks a word produced under flush.
- `m_valid`  out  1  — output word valid.
- `m_ready`  in  1  — downstream accept.
- `words_out`  out  CNT_W  — count of accepted words, wrapping.

## Operation
- **State:**
  - `asm` register: 4 lanes, 32 bits.
  - `asm_cnt`: 0..4.
  - `rd_pending`: a read issued last cycle.
  - output register: `m_data`, `m_keep`, `m_last`, `m_valid`.
  - `flush_pend`.
  - `words_out`.
- **Transfer condition:** `xfer = (asm_cnt==4 || (flush_pend && !rd_pending && asm_cnt!=0)) && (!m_valid || m_ready)`.
- **Read strobe:** `rd_en = !rd_rst && !fifo_empty && !flush_pend && ((asm_cnt + rd_pending < 4) || xfer)`. This is combinational.
  - `rd_en` is never high while `fifo_empty=1`.
- **Capture:** on an edge with `rd_pending=1`, `fifo_out` is written into lane `asm_cnt`, and `asm_cnt` increments.
  - If `xfer` happens on the same edge, the byte goes to lane 0 and `asm_cnt` becomes 1.
- **Transfer:** on `xfer`:
  - `m_data` takes `asm`, with unused lanes forced to 0.
  - `m_keep` takes `(1<<asm_cnt)-1`.
  - `m_last` takes `flush_pend`.
  - `m_valid` is set to 1.
  - `asm` is cleared and `asm_cnt` returns to 0, unless the capture rule above applies.
- **Handshake:**
  - A word is accepted on an edge with `m_valid && m_ready`.
  - After acceptance, `m_valid` clears unless a new `xfer` reloads it on the same edge.
  - While `m_valid && !m_ready`, all output signals hold stable.
- **Flush:**
  - `flush` sets `flush_pend`, which inhibits new reads.
  - Once `rd_pending=0`:
    - If `asm_cnt>0`, the partial word transfers with `m_last=1`, and `flush_pend` clears on that edge.
    - If `asm_cnt==0`, `flush_pend` clears on the next edge and no word is emitted.
  - If `asm_cnt==4` while a flush is pending, a full word is emitted with `m_keep=4'hF` and `m_last=1`.
  - `flush` while `flush_pend` is already set is ignored.
- **Counter:** `words_out` increments on each accept and wraps at 2^CNT_W.

## Timing
- **Reset:** `rd_rst` high clears all registers immediately, without waiting for a clock edge:
  - `m_data=0`, `m_keep=0`, `m_last=0`, `m_valid=0`;
  - `asm_cnt=0`, `rd_pending=0`, `flush_pend=0`, `words_out=0`.
  - `rd_en=0` for as long as `rd_rst` is high.
  - A read in flight at reset is discarded. The FIFO read side shares `rd_rst`.
- **Read latency:** a byte strobed at edge N is captured at edge N+1.
- **First-word latency:** with a non-empty FIFO, `m_valid` rises 5 edges after the first `rd_en` edge.
- **Throughput:** sustained rate is 4 bytes per 5 cycles with `m_ready=1`. The bubble comes from slot accounting.
- **Flush latency:** with no read in flight, the flushed word is valid 1 edge after the `flush` edge. Add 1 edge if a read is pending.
- **Backpressure:** with `m_valid=1` and `m_ready=0`, the assembly register may fill to 4. Once full, `rd_en` stays low until the output frees.
- **Idle:** the empty FIFO going non-empty mid-word simply resumes filling. There is no timeout.

## Test plan
1. **Reset values:** assert `rd_rst` mid-clock with no clock edge. All outputs read 0 immediately, and `rd_en` is 0 throughout reset.
2. **Full stream:** preload the FIFO with 64 bytes 0x00..0x3F, `m_ready=1`.
   - Expect 16 words: 0x03020100, 0x07060504, …, 0x3F3E3D3C.
   - Each word has `m_keep=F` and `m_last=0`; `words_out` ends at 16.
   - `rd_en` is never high while `fifo_empty=1`.
3. **Backpressure:** 8 bytes, `m_ready=0`.
   - Word 0x03020100 holds stable.
   - `asm_cnt` reaches 4 and `rd_en` stays low with 0 reads outstanding.
   - Raise `m_ready`: the next word is 0x07060504, and the FIFO ends empty.
4. **Flush partial:** bytes AA, BB, CC, then `flush`.
   - Expect a single word `m_data=0x00CCBBAA`, `m_keep=0111`, `m_last=1`.
   - Reads resume after `flush_pend` clears.
5. **Flush when empty:** `flush` with `asm_cnt=0` and no read in flight. No word is emitted, and `flush_pend` clears after 1 edge.
6. **Reset mid-word:** after bytes 11 and 22 are captured, pulse `rd_rst`.
   - `asm` and `m_valid` clear.
   - The following bytes 33, 44, 55, 66 yield 0x66554433.
